// File: rtl/md_unit.sv
// md_unit: multiply/divide controller for the pipelined MIPS core.
//
// The E stage launches mult/multu/div/divu here. The product or quotient is
// computed combinationally in the launch cycle and parked in pHI/pLO. A down
// counter then models the fixed latency, and the parked result is committed to
// HI/LO on the edge where the counter reaches zero. mthi/mtlo write HI/LO
// directly when the unit is idle. mfhi/mflo read the committed registers
// through MDUOut.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high clear of all state
//   Start   in   E-stage launch strobe
//   MDUOp   in   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
//   A, B    in   forwarded rs / rt
//   D_hilo  in   D-stage instruction touches HI/LO
//   Busy    out  operation in progress
//   Stall   out  D-stage stall request
//   HI, LO  out  committed HI/LO registers
//   MDUOut  out  mfhi/mflo result, 0 for other ops
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_hilo,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [31:0] r_hi, r_lo, r_phi, r_plo;
  logic [3:0]  r_cnt;

  logic        w_is_md, w_launch;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_mag_q, w_mag_r;
  logic [31:0] w_res_hi, w_res_lo;
  logic [3:0]  w_cycles;

  assign w_is_md  = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
  assign Busy     = (r_cnt != 4'd0);
  assign w_launch = Start && w_is_md && !Busy;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide done on magnitudes, then signs restored: quotient truncates
  // toward zero and the remainder follows the dividend. This also yields
  // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign w_abs_a = A[31] ? (~A + 32'd1) : A;
  assign w_abs_b = B[31] ? (~B + 32'd1) : B;
  assign w_mag_q = w_abs_a / w_abs_b;
  assign w_mag_r = w_abs_a % w_abs_b;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_cycles = 4'(MULT_CYCLES);
    case (MDUOp)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV: begin
        w_cycles = 4'(DIV_CYCLES);
        // Divide by zero keeps the current HI/LO as the pending result.
        if (B != 32'd0) begin
          w_res_lo = (A[31] ^ B[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
          w_res_hi = A[31] ? (~w_mag_r + 32'd1) : w_mag_r;
        end
      end
      OP_DIVU: begin
        w_cycles = 4'(DIV_CYCLES);
        if (B != 32'd0) begin
          w_res_lo = A / B;
          w_res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
      r_cnt <= 4'd0;
    end else if (Busy) begin
      // Launch and move-to requests are dropped while counting.
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (w_launch) begin
      r_phi <= w_res_hi;
      r_plo <= w_res_lo;
      r_cnt <= w_cycles;
    end else if (MDUOp == OP_MTHI) begin
      r_hi <= A;
    end else if (MDUOp == OP_MTLO) begin
      r_lo <= A;
    end
  end

  // Gated by reset so the hazard unit sees no stall while the unit is held clear.
  assign Stall  = !reset && D_hilo && (Busy || (Start && w_is_md));
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign MDUOut = (MDUOp == OP_MFHI) ? r_hi :
                  (MDUOp == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        D_hilo;
  logic        Busy, Stall;
  logic [31:0] HI, LO, MDUOut;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .D_hilo(D_hilo), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO),
    .MDUOut(MDUOut)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: committed and pending HI/LO plus the edge number at
  // which the pending result lands. Busy is "edges so far < landing edge".
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int unsigned cyc, m_done;
  logic        last_stall, last_busy;
  logic [31:0] last_out;
  string       phase;
  int          nst, nbusy;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s:%s observed=%08h expected=%08h", phase, tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s:%s observed=%b expected=%b", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_done = 0;
  endtask

  task automatic model_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb;                   m_phi = p[63:32]; m_plo = p[31:0]; m_done = cyc + 1 + MULT_N; end
      4'd2: begin p = {32'd0, a} * {32'd0, b};   m_phi = p[63:32]; m_plo = p[31:0]; m_done = cyc + 1 + MULT_N; end
      4'd3: begin
        if (b == 0) begin m_phi = m_hi; m_plo = m_lo; end
        else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
        m_done = cyc + 1 + DIV_N;
      end
      default: begin
        if (b == 0) begin m_phi = m_hi; m_plo = m_lo; end
        else begin m_plo = a / b; m_phi = a % b; end
        m_done = cyc + 1 + DIV_N;
      end
    endcase
  endtask

  task automatic model_edge();
    int unsigned e;
    e = cyc + 1;
    if (cyc < m_done) begin
      if (e == m_done) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (Start && MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
      model_launch(MDUOp, A, B);
    end else if (MDUOp == 4'd7) begin
      m_hi = A;
    end else if (MDUOp == 4'd8) begin
      m_lo = A;
    end
    cyc = e;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, clock, update model.
  task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic dh);
    logic        eb, is_md;
    logic [31:0] eo;
    Start = s; MDUOp = op; A = a; B = b; D_hilo = dh;
    @(negedge clk);
    eb    = (cyc < m_done);
    is_md = (op >= 4'd1) && (op <= 4'd4);
    eo    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    check1("busy", Busy, eb);
    check1("stall", Stall, dh & (eb | (s & is_md)));
    check32("mduout", MDUOut, eo);
    check32("hi", HI, m_hi);
    check32("lo", LO, m_lo);
    last_stall = Stall; last_busy = Busy; last_out = MDUOut;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic dh);
    repeat (n) step(1'b0, 4'd0, 32'd0, 32'd0, dh);
  endtask

  initial begin
    phase = "reset";
    cyc = 0;
    model_reset();
    reset = 1'b1; Start = 1'b1; MDUOp = 4'd1; A = 32'd9; B = 32'd9; D_hilo = 1'b1;
    @(posedge clk); #1;
    check1("busy", Busy, 1'b0);
    check1("stall", Stall, 1'b0);
    check32("hi", HI, 32'd0);
    check32("lo", LO, 32'd0);
    reset = 1'b0; Start = 1'b0; MDUOp = 4'd0; D_hilo = 1'b0;

    phase = "mult";
    step(1'b1, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    nbusy = 0;
    for (int i = 0; i < int'(MULT_N) + 1; i++) begin step(1'b0, 4'd0, 0, 0, 1'b0); nbusy += int'(last_busy); end
    check32("busy_cycles", 32'(nbusy), 32'd5);
    check32("hi_const", HI, 32'hFFFFFFFF);
    check32("lo_const", LO, 32'hFFFFFFFA);
    step(1'b0, 4'd5, 0, 0, 1'b0);
    check32("mfhi_const", last_out, 32'hFFFFFFFF);

    phase = "multu";
    step(1'b1, 4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    idle(MULT_N, 1'b0);
    check32("hi_const", HI, 32'h00000002);
    check32("lo_const", LO, 32'hFFFFFFFA);

    phase = "div_stall";
    nst = 0;
    step(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    nst += int'(last_stall);
    for (int i = 0; i < int'(DIV_N); i++) begin step(1'b0, 4'd0, 0, 0, 1'b1); nst += int'(last_stall); end
    step(1'b0, 4'd6, 0, 0, 1'b1);
    check1("stall_after", last_stall, 1'b0);
    check32("mflo_new", last_out, 32'hFFFFFFFD);
    check32("stall_cycles", 32'(nst), 32'd11);
    check32("hi_const", HI, 32'hFFFFFFFF);

    phase = "divu_zero";
    step(1'b1, 4'd4, 32'd7, 32'd0, 1'b0);
    nbusy = 0;
    for (int i = 0; i < int'(DIV_N) + 1; i++) begin step(1'b0, 4'd0, 0, 0, 1'b0); nbusy += int'(last_busy); end
    check32("busy_cycles", 32'(nbusy), 32'd10);
    check32("hi_const", HI, 32'hFFFFFFFF);
    check32("lo_const", LO, 32'hFFFFFFFD);

    phase = "mt_busy";
    step(1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
    step(1'b0, 4'd8, 32'h1234, 32'd0, 1'b0);
    idle(MULT_N - 1, 1'b0);
    check32("lo_const", LO, 32'd6);
    step(1'b0, 4'd8, 32'h1234, 32'd0, 1'b0);
    check32("mtlo_const", LO, 32'h1234);
    step(1'b0, 4'd6, 0, 0, 1'b0);
    check32("mflo_const", last_out, 32'h1234);
    step(1'b0, 4'd5, 0, 0, 1'b0);
    check32("mfhi_const", last_out, 32'd0);

    phase = "div_ovf";
    step(1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(DIV_N, 1'b0);
    check32("lo_const", LO, 32'h80000000);
    check32("hi_const", HI, 32'd0);
    step(1'b0, 4'd7, 32'hA5A5_0F0F, 32'd0, 1'b0);
    check32("mthi_const", HI, 32'hA5A5_0F0F);

    phase = "reset_mid";
    step(1'b1, 4'd1, 32'd3, 32'd5, 1'b1);
    idle(2, 1'b1);
    Start = 1'b0; MDUOp = 4'd0; D_hilo = 1'b1;
    #2 reset = 1'b1;
    #1;
    check1("busy", Busy, 1'b0);
    check1("stall", Stall, 1'b0);
    check32("hi", HI, 32'd0);
    check32("lo", LO, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(MULT_N + 2, 1'b1);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] ra, rb;
      logic        rs, rd;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      rs = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) ra = 32'h80000000;
      step(rs, op, ra, rb, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
